// File: rtl/mdu_sched_pkg.sv
// Shared constants for the multiply/divide unit scheduler.
// Operation encodings, latency defaults and counter sizing.
package mdu_sched_pkg;

  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Counter holds N-1 for the longest op, never narrower than 4 bits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Produces {hi,lo} result and a divide-by-zero flag.
module md_arith
  import mdu_sched_pkg::*;
(
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        is_mul;
  logic        is_div;
  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_mul  = (mdop == MDOP_MULT) || (mdop == MDOP_MULTU);
  assign is_div  = (mdop == MDOP_DIV) || (mdop == MDOP_DIVU);
  assign sgn_mul = (mdop == MDOP_MULT);
  assign sgn_div = (mdop == MDOP_DIV);

  assign op_a = {{32{sgn_mul & rs_val[31]}}, rs_val};
  assign op_b = {{32{sgn_mul & rt_val[31]}}, rt_val};
  assign prod = op_a * op_b;

  // Divide on magnitudes, then restore signs: quotient truncates
  // toward zero, remainder follows the dividend.
  assign a_neg = sgn_div & rs_val[31];
  assign b_neg = sgn_div & rt_val[31];
  assign mag_a = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign mag_b = b_neg ? (~rt_val + 32'd1) : rt_val;
  assign dvs   = (rt_val == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvs;
  assign ur    = mag_a % dvs;
  assign quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
  assign rem   = a_neg ? (~ur + 32'd1) : ur;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    div0   = 1'b0;
    unique case (1'b1)
      is_mul: {res_hi, res_lo} = prod;
      is_div: begin
        div0   = (rt_val == 32'd0);
        res_hi = rem;
        res_lo = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: busy counter, HI/LO ownership
// and the D-stage stall for instructions touching the unit.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mdop,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_isdm,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_skip;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          div0;
  logic          issue_op;
  logic          is_div;
  logic          idle_ok;
  logic          go;

  md_arith u_arith (
    .mdop   (mdop),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (div0)
  );

  assign issue_op = (mdop == MDOP_MULT) || (mdop == MDOP_MULTU) ||
                    (mdop == MDOP_DIV)  || (mdop == MDOP_DIVU);
  assign is_div   = (mdop == MDOP_DIV) || (mdop == MDOP_DIVU);
  assign idle_ok  = !cancel && (state == S_IDLE);
  assign go       = issue_op && idle_ok;

  assign busy  = (state == S_BUSY);
  // Issue term covers the cycle before busy rises.
  assign stall = d_isdm && (busy || (issue_op && !cancel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_skip <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_skip <= div0;
            cnt       <= is_div ? CW'(DIV_CYCLES - 1)
                                : CW'(MULT_CYCLES - 1);
            state     <= S_BUSY;
          end else if (idle_ok && (mdop == MDOP_MTHI)) begin
            hi <= rs_val;
          end else if (idle_ok && (mdop == MDOP_MTLO)) begin
            lo <= rs_val;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            if (!pend_skip) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with an expected-result queue.
// Reference results come from plain integer arithmetic.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mdop = MDOP_NONE;
  logic        cancel = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        d_isdm = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  mdu_sched dut (
    .clk    (clk),
    .reset  (reset),
    .mdop   (mdop),
    .cancel (cancel),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .d_isdm (d_isdm),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // No new op may be presented while the unit is busy.
  always @(negedge clk) begin
    if (!reset && busy) begin
      n_assert++;
      assert (mdop == MDOP_NONE || mdop == 3'd7) else begin
        n_fail++;
        $error("FAIL mdop_in_busy observed=%h expected=0", mdop);
      end
    end
  end

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      MDOP_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MDOP_MULTU: return {32'd0, a} * {32'd0, b};
      MDOP_DIV: begin
        if (b == 0) return {ch, cl};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      MDOP_DIVU: begin
        if (b == 0) return {ch, cl};
        return {a % b, a / b};
      end
      default: return {ch, cl};
    endcase
  endfunction

  // Called just after a rising edge; leaves the bench just after
  // the rising edge that follows the first idle cycle.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic dsm, input logic cib);
    int n;
    int cyc;
    logic [63:0] e;
    n = (op == MDOP_DIV || op == MDOP_DIVU) ? 10 : 5;
    exp_q.push_back(model(op, a, b, cur_hi, cur_lo));
    mdop = op;
    rs_val = a;
    rt_val = b;
    d_isdm = dsm;
    cancel = 1'b0;
    @(negedge clk);
    chk({tag, "_issue_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_issue_stall"}, {31'd0, stall}, {31'd0, dsm});
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    cancel = cib;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (dsm) chk({tag, "_busy_stall"}, {31'd0, stall}, 32'd1);
    end
    chk({tag, "_busy_cycles"}, cyc, n);
    chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, hi, e[63:32]);
      chk({tag, "_lo"}, lo, e[31:0]);
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    d_isdm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("mult", MDOP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("mult_plan_lo", cur_lo, 32'hFFFF_FFFE);
    do_op("multu", MDOP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("multu_plan_hi", cur_hi, 32'h1);
    do_op("div", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_plan_lo", cur_lo, 32'hFFFF_FFFD);
    do_op("divu0", MDOP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    do_op("divovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("divneg", MDOP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("divu", MDOP_DIVU, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    do_op("mstall", MDOP_MULT, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0);

    // Issue cancelled: no busy, no stall, no change.
    mdop = MDOP_MULT;
    rs_val = 32'h55;
    rt_val = 32'h77;
    cancel = 1'b1;
    d_isdm = 1'b1;
    @(negedge clk);
    chk("cxl_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    cancel = 1'b0;
    d_isdm = 1'b0;
    @(negedge clk);
    chk("cxl_busy", {31'd0, busy}, 32'd0);
    chk("cxl_hi", hi, cur_hi);
    chk("cxl_lo", lo, cur_lo);
    @(posedge clk); #1;

    do_op("cib", MDOP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

    // mthi then cancelled mtlo.
    mdop = MDOP_MTHI;
    rs_val = 32'h1234;
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    cur_hi = 32'h1234;
    @(posedge clk); #1;
    mdop = MDOP_MTLO;
    rs_val = 32'hDEAD_BEEF;
    cancel = 1'b1;
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    cancel = 1'b0;
    @(negedge clk);
    chk("mtlo_cxl_lo", lo, cur_lo);
    @(posedge clk); #1;
    mdop = MDOP_MTLO;
    rs_val = 32'hCAFE_0001;
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hCAFE_0001);
    cur_lo = 32'hCAFE_0001;
    @(posedge clk); #1;

    // Async reset in the third busy cycle of a div.
    mdop = MDOP_DIV;
    rs_val = 32'd1000;
    rt_val = 32'd7;
    @(posedge clk); #1;
    mdop = MDOP_NONE;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_op("post_rst", MDOP_DIV, 32'd1000, 32'd7, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide unit scheduler for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from the E stage and models the multi-cycle latency with a busy counter. It owns the HI/LO registers and raises the pipeline stall for any D-stage instruction that uses the unit (`isdm` from the decoder) while an operation is in flight. It also honours exception/interrupt cancellation of the operation being issued.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `mdop` in 3: E-stage operation. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none.
- `cancel` in 1: exception/interrupt taken this cycle; suppresses the E-stage `mdop`.
- `rs_val` in 32: forwarded rs operand in E.
- `rt_val` in 32: forwarded rt operand in E.
- `d_isdm` in 1: D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `busy` out 1: operation in flight.
- `stall` out 1: combinational; freeze F/D, bubble E.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, BUSY. Down-counter `cnt`, 4 bits minimum, sized for max(MULT_CYCLES, DIV_CYCLES).
- Issue `go` = `mdop` in 1..4, `!cancel`, state IDLE.
  - On the edge: latch result into `pend_hi`/`pend_lo`.
  - Load `cnt` = N−1; go to BUSY.
- mult/multu: 64-bit product, signed/unsigned; `{hi,lo}` = product.
- div/divu: LO = quotient, HI = remainder, truncating toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
  - Divisor 0: HI/LO unchanged after completion. The unit is still busy for DIV_CYCLES.
- BUSY:
  - `cnt` decrements each edge.
  - On the edge where `cnt`==0: copy `pend_hi`/`pend_lo` into `hi`/`lo`, return to IDLE.
- mthi/mtlo with `!cancel` in IDLE: `hi` (or `lo`) = `rs_val` on the next edge. `busy` stays low.
- `cancel` gates only issue. An operation already BUSY always completes.
- `mdop` ≠ none while BUSY: ignored. The stall protocol makes this unreachable; the bench asserts it never occurs.
- `stall` = `d_isdm` && (`busy` || `mdop` in 1..4). The second term covers the issue cycle, before `busy` rises.

## Timing
- Reset values: state IDLE, `cnt`=0, `busy`=0, `stall`=0 unless `d_isdm`, `hi`=0, `lo`=0, pend regs=0.
- Issue sampled at edge t0. `busy`=1 for exactly N cycles (t0..t0+N). New `hi`/`lo` are visible from the edge ending the last busy cycle.
- An mfhi held in D by `stall` enters E in the first cycle with `busy`=0 and reads the committed value.
- Back-to-back: a new issue is accepted in the cycle after `busy` falls, not in the same cycle.
- mthi/mtlo: one-edge latency, no busy.
- `reset` asserted mid-BUSY: immediate abort, `hi`/`lo`=0, `busy`=0 without waiting for the clock.
- `cancel` and a valid `mdop` in the same cycle: no state change, and the issue term of `stall` is also masked.

## Structure
- Shared constants header (alongside the opcode/funct defines): `MDOP_*` encodings, `MULT_CYCLES`/`DIV_CYCLES` defaults.
- One combinational sub-module, `md_arith`: inputs `mdop`, `rs_val`, `rt_val`; outputs the 64-bit `{res_hi,res_lo}` and `div0`. The scheduler FSM, counter, and HI/LO registers stay in `mdu_sched`.

## Test plan
- mult: rs=0xFFFFFFFF, rt=2 → `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. With multu on the same operands → hi=0x1, lo=0xFFFFFFFE.
- div: rs=−7, rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with rt=0 → hi/lo unchanged.
- Stall: issue mult with `d_isdm`=1 (mflo behind it) → `stall`=1 in the issue cycle and all 5 busy cycles, 0 in the next cycle, where lo reads the new value.
- Cancel: mult with `cancel`=1 → `busy` stays 0, hi/lo unchanged. Then `cancel` during BUSY → the operation still commits.
- mthi rs=0x1234 → hi=0x1234 one edge later, `busy`=0. An mtlo with `cancel` → lo unchanged.
- Async reset asserted at cycle 3 of a div → `busy`, hi, lo go to 0 before the next edge; the next div issues normally.
